// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the core's load/store port.
// One request at a time over valid/ready, RISC-V byte/half/word semantics
// selected by func3, and a registered response after LATENCY rising edges.
// Optional feature: define MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors; otherwise the low address bits are forced to alignment.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. req_ready is high only in IDLE (and never while rst is high).
// rsp_valid stays high, with rsp_rdata/rsp_error held, until rsp_ready is seen
// at an edge.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_src_write;
  logic [2:0]  w_src_func3;
  logic [31:0] w_src_addr;
  logic [31:0] w_src_wdata;
  logic [AW-1:0] w_widx;
  logic        w_in_range;
  logic        w_func_ok;
  logic        w_misalign;
  logic        w_error;
  logic [31:0] w_rword;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wword;

  assign w_accept     = req_valid & req_ready;
  assign w_enter_resp = ((r_state == S_IDLE) && w_accept && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With LATENCY=1 the response is formed on the accepting edge itself, so the
  // live request fields are used while in IDLE and the captured ones otherwise.
  assign w_src_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_src_func3 = (r_state == S_IDLE) ? req_func3 : r_func3;
  assign w_src_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_src_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_widx     = w_src_addr[AW+1:2];
  assign w_in_range = ({2'b00, w_src_addr[31:2]} < 32'(DEPTH_WORDS));
  assign w_rword    = r_mem[w_widx];

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((w_src_func3[1:0] == 2'b01) && w_src_addr[0]) ||
                      ((w_src_func3[1:0] == 2'b10) && (w_src_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_error = ~w_func_ok | ~w_in_range | w_misalign;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> WAIT (or RESP when LATENCY=1) -> RESP -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs; req_ready is suppressed while reset is asserted.
  always_comb begin
    req_ready = (r_state == S_IDLE) && !rst;
    busy      = (r_state == S_WAIT) || (r_state == S_RESP);
    dbg_state = r_state;
  end

  // Latency counter: loaded on accept, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture on the accepting edge; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_func3 <= req_func3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Legal func3 codes per direction.
  always_comb begin
    w_func_ok = 1'b0;
    if (w_src_write) w_func_ok = (w_src_func3 == 3'b000) || (w_src_func3 == 3'b001) ||
                                 (w_src_func3 == 3'b010);
    else             w_func_ok = (w_src_func3 == 3'b000) || (w_src_func3 == 3'b001) ||
                                 (w_src_func3 == 3'b010) || (w_src_func3 == 3'b100) ||
                                 (w_src_func3 == 3'b101);
  end

  // Load lane select and sign/zero extension; half uses addr[1] only, so a
  // misaligned half naturally ignores addr[0] and a word ignores addr[1:0].
  always_comb begin
    w_byte = w_rword[{w_src_addr[1:0], 3'b000} +: 8];
    w_half = w_src_addr[1] ? w_rword[31:16] : w_rword[15:0];
    w_load = 32'd0;
    case (w_src_func3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_rword;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // Store merge: only the targeted lanes of the current word change.
  always_comb begin
    w_wword = w_rword;
    case (w_src_func3)
      3'b000: w_wword[{w_src_addr[1:0], 3'b000} +: 8] = w_src_wdata[7:0];
      3'b001: begin
        if (w_src_addr[1]) w_wword[31:16] = w_src_wdata[15:0];
        else               w_wword[15:0]  = w_src_wdata[15:0];
      end
      3'b010:  w_wword = w_src_wdata;
      default: w_wword = w_rword;
    endcase
  end

  // Storage commit on entry into RESP; never on an edge where reset is high.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_src_write && !w_error) r_mem[w_widx] <= w_wword;
  end

  // Response registers: loaded on entry into RESP, cleared by the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_error <= 1'b0;
    end else if (w_enter_resp) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (w_src_write || w_error) ? 32'd0 : w_load;
      r_rsp_error <= w_error;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (DEPTH_WORDS=1024,
// LATENCY=2). Expected values are hand-computed constants.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, check acceptance and latency, optionally stall the
  // response for 'hold' cycles while a second request is offered, then
  // complete the handshake.
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    // Junk on the request bus while busy must be ignored.
    req_valid = 1'b0; req_write = 1'b1; req_func3 = 3'b010;
    req_addr = 32'h0000_0010; req_wdata = 32'h0BAD_0BAD;
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(LATENCY));
    rd  = rsp_rdata;
    err = rsp_error;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    chk("idle_after_handshake", 32'(busy), 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    // Reset: outputs zero, req_ready low while rst is high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // sw / lw.
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, err);
    chk("sw_err", 32'(err), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(err), 32'd0);

    // sb over a known word.
    txn(1'b1, 3'b010, 32'h10, 32'h11223344, 0, rd, err);
    txn(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, rd, err);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err);
    chk("lw_after_sb", rd, 32'hA5223344);
    txn(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, err);
    chk("lb_13", rd, 32'hFFFFFFA5);
    txn(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, err);
    chk("lbu_13", rd, 32'h000000A5);

    // sh upper half.
    txn(1'b1, 3'b001, 32'h12, 32'h00008001, 0, rd, err);
    txn(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, err);
    chk("lh_12", rd, 32'hFFFF8001);
    txn(1'b0, 3'b101, 32'h12, 32'h0, 0, rd, err);
    chk("lhu_12", rd, 32'h00008001);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err);
    chk("lw_after_sh", rd, 32'h80013344);

    // Response stall of 5 cycles with a second request pending (a store to
    // 0x10); word 0x10 must be unchanged afterwards.
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, err);
    chk("stall_rdata", rd, 32'h80013344);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err);
    chk("no_accept_during_resp", rd, 32'h80013344);

    // Errors: out of range store (would alias word 0), bad func3.
    txn(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 0, rd, err);
    txn(1'b1, 3'b010, 32'(4 * DEPTH), 32'h12345678, 0, rd, err);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    txn(1'b0, 3'b010, 32'h0, 32'h0, 0, rd, err);
    chk("oor_no_write", rd, 32'hCAFEF00D);
    txn(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 0, rd, err);
    chk("oor_load_err", 32'(err), 32'd1);
    txn(1'b1, 3'b011, 32'h10, 32'h55555555, 0, rd, err);
    chk("f3_011_err", 32'(err), 32'd1);
    chk("f3_011_rdata", rd, 32'd0);
    txn(1'b1, 3'b100, 32'h10, 32'h55555555, 0, rd, err);
    chk("store_f3_100_err", 32'(err), 32'd1);
    txn(1'b0, 3'b110, 32'h10, 32'h0, 0, rd, err);
    chk("load_f3_110_err", 32'(err), 32'd1);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err);
    chk("mem_unchanged_after_errs", rd, 32'h80013344);

    // Misaligned word load.
    txn(1'b0, 3'b010, 32'h12, 32'h0, 0, rd, err);
`ifdef MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(err), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
`else
    chk("lw_mis_err", 32'(err), 32'd0);
    chk("lw_mis_rdata", rd, 32'h80013344);
`endif
    // Misaligned half load at 0x13 (half lane 1).
    txn(1'b0, 3'b001, 32'h13, 32'h0, 0, rd, err);
`ifdef MISALIGN_TRAP_EN
    chk("lh_mis_err", 32'(err), 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
`else
    chk("lh_mis_err", 32'(err), 32'd0);
    chk("lh_mis_rdata", rd, 32'hFFFF8001);
`endif

    // Reset during WAIT abandons a store.
    txn(1'b1, 3'b010, 32'h20, 32'hAAAA0000, 0, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_error", 32'(rsp_error), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, err);
    chk("store_abandoned", rd, 32'hAAAA0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout tests=%0d", tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
